// File: rtl/ib_ram_bank_ctlr_if.sv
// ib_ram_bank_ctlr_if: inbound stream, RAM write and bank read-handshake signals
interface ib_ram_bank_ctlr_if #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W = 9
);
    localparam int BW = $clog2(NUM_BANKS);
    logic s_tvalid, s_tlast, s_tready, enable_use_ram;
    logic wr_en;
    logic [BW+ADDR_W-1:0] wr_addr;
    logic rd_valid;
    logic [BW-1:0] rd_bank;
    logic [ADDR_W:0] rd_len;
    logic rd_start, rd_done;
    logic [BW:0] ready_cnt;
    logic [15:0] drop_cnt;
    logic oversize_err;
    modport master (
        output s_tvalid, s_tlast, enable_use_ram, rd_start, rd_done,
        input s_tready, wr_en, wr_addr, rd_valid, rd_bank, rd_len, ready_cnt, drop_cnt, oversize_err
    );
    modport slave (
        input s_tvalid, s_tlast, enable_use_ram, rd_start, rd_done,
        output s_tready, wr_en, wr_addr, rd_valid, rd_bank, rd_len, ready_cnt, drop_cnt, oversize_err
    );
endinterface

// File: rtl/ib_ram_bank_ctlr.sv
// ib_ram_bank_ctlr: multi-bank inbound packet buffer ownership, write addressing and in-order hand-off
module ib_ram_bank_ctlr #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W = 9,
    parameter bit DROP_WHEN_FULL = 0
) (
    input logic clk,
    input logic rst_n,
    ib_ram_bank_ctlr_if.slave bus
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [ADDR_W:0] FULL_OFF = {1'b1, {ADDR_W{1'b0}}};
    typedef enum logic [1:0] {FREE, FILLING, READY, BUSY} bank_st_t;
    typedef logic [BW:0] cnt_t;
    bank_st_t bank_st [NUM_BANKS];
    logic [ADDR_W:0] bank_len [NUM_BANKS];
    logic [BW-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] offset, off_now;
    logic in_pkt, pkt_store, pkt_drop;
    logic first, wr_free, store_now, drop_now, over_now, acc, last_acc;
    logic store_ok, over_evt, drop_evt, rd_go, rd_rel;

    assign first = !in_pkt;
    assign wr_free = bank_st[wr_ptr] == FREE;
    assign store_now = first ? (bus.enable_use_ram && wr_free) : pkt_store;
    assign drop_now = first ? (bus.enable_use_ram && !wr_free) : pkt_drop;
    assign bus.s_tready = !(first && bus.enable_use_ram && !wr_free && !DROP_WHEN_FULL);
    assign acc = bus.s_tvalid && bus.s_tready;
    assign last_acc = acc && bus.s_tlast;
    assign off_now = first ? '0 : offset;
    assign over_now = off_now == FULL_OFF;
    assign bus.wr_en = acc && store_now && !over_now;
    assign bus.wr_addr = {wr_ptr, off_now[ADDR_W-1:0]};
    assign store_ok = last_acc && store_now && !over_now;
    assign over_evt = last_acc && store_now && over_now;
    assign drop_evt = over_evt || (last_acc && drop_now);
    assign rd_rel = bus.rd_done && bank_st[rd_ptr] == BUSY;
    assign rd_go = bus.rd_start && !bus.rd_done && bank_st[rd_ptr] == READY;
    assign bus.rd_valid = bank_st[rd_ptr] == READY;
    assign bus.rd_bank = rd_ptr;
    assign bus.rd_len = bank_len[rd_ptr];

    // Bank ownership, packet tracking and status counters; write and read sides always hit different banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_st[i] <= FREE;
                bank_len[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            offset <= '0;
            in_pkt <= 1'b0;
            pkt_store <= 1'b0;
            pkt_drop <= 1'b0;
            bus.ready_cnt <= '0;
            bus.drop_cnt <= '0;
            bus.oversize_err <= 1'b0;
        end else begin
            if (acc) begin
                in_pkt <= !bus.s_tlast;
                pkt_store <= store_now;
                pkt_drop <= drop_now;
            end
            if (bus.wr_en) offset <= off_now + 1'b1;
            else if (acc && first) offset <= '0;
            if (acc && first && store_now) bank_st[wr_ptr] <= FILLING;
            if (store_ok) begin
                bank_st[wr_ptr] <= READY;
                bank_len[wr_ptr] <= off_now + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (over_evt) begin
                bank_st[wr_ptr] <= FREE;
                bus.oversize_err <= 1'b1;
            end
            if (drop_evt && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + 1'b1;
            if (rd_go) bank_st[rd_ptr] <= BUSY;
            if (rd_rel) begin
                bank_st[rd_ptr] <= FREE;
                rd_ptr <= rd_ptr + 1'b1;
            end
            bus.ready_cnt <= bus.ready_cnt + cnt_t'(store_ok) - cnt_t'(rd_rel);
        end
    end
endmodule
